regfile_wb_arbiter: RTL and testbench

//  Write-side front end of the 32x32 register file: merges the single-cycle ALU writeback
//  and the long-latency LSU/load writeback into the one RF write port (RegWrite/rd/WriteData).
//  LSU results are buffered in a small FIFO. A pending-destination scoreboard drives hazard stalls.

---
 rtl/regfile_wb_arbiter.sv | 146 ++++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 425 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
// Register-file write-port arbiter: merges single-cycle ALU writebacks with buffered LSU
// writebacks, tracks registers awaiting LSU data and forces ALU stalls when the FIFO starves.
module regfile_wb_arbiter #(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        alu_wb_en,
    input  logic [4:0]                  alu_wb_rd,
    input  logic [XLEN-1:0]             alu_wb_data,
    input  logic                        lsu_wb_valid,
    output logic                        lsu_wb_ready,
    input  logic [4:0]                  lsu_wb_rd,
    input  logic [XLEN-1:0]             lsu_wb_data,
    input  logic                        issue_en,
    input  logic [4:0]                  issue_rd,
    output logic [31:0]                 busy_mask,
    output logic                        alu_stall,
    output logic                        waw_err,
    output logic                        rf_we,
    output logic [4:0]                  rf_rd,
    output logic [XLEN-1:0]             rf_wdata,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
    localparam int unsigned CntW = PtrW + 1;
    localparam int unsigned StvW = $clog2(STARVE_MAX + 1);
    localparam logic [CntW-1:0] DepthC  = CntW'(FIFO_DEPTH);
    localparam logic [StvW-1:0] StarveC = StvW'(STARVE_MAX);

    logic [4:0]      rd_mem   [FIFO_DEPTH];
    logic [XLEN-1:0] data_mem [FIFO_DEPTH];

    logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0] count_q, count_d;
    logic [StvW-1:0] starve_q, starve_d;
    logic [31:0]     busy_q, busy_d;
    logic            rf_we_q, rf_we_d;
    logic [4:0]      rf_rd_q, rf_rd_d;
    logic [XLEN-1:0] rf_wdata_q, rf_wdata_d;
    logic            waw_q, waw_d;

    logic            fifo_empty;
    logic            push;
    logic            pop;
    logic            alu_req;
    logic [4:0]      head_rd;
    logic [XLEN-1:0] head_data;

    assign fifo_empty   = (count_q == '0);
    // Ready depends only on the registered count, so a full FIFO refuses even while popping.
    assign lsu_wb_ready = (count_q < DepthC);
    assign alu_stall    = (starve_q >= StarveC);
    // rd==0 entries complete the handshake but are never stored.
    assign push         = lsu_wb_valid && lsu_wb_ready && (lsu_wb_rd != 5'd0);
    // ALU requests during a stall are dropped outright.
    assign alu_req      = alu_wb_en && (alu_wb_rd != 5'd0) && !alu_stall;
    assign pop          = !fifo_empty && (alu_stall || !alu_req);
    assign head_rd      = rd_mem[rd_ptr_q];
    assign head_data    = data_mem[rd_ptr_q];

    assign busy_mask  = busy_q;
    assign waw_err    = waw_q;
    assign rf_we      = rf_we_q;
    assign rf_rd      = rf_rd_q;
    assign rf_wdata   = rf_wdata_q;
    assign fifo_count = count_q;

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase

        starve_d = starve_q;
        if (fifo_empty || pop) begin
            starve_d = '0;
        end else if (starve_q != StarveC) begin
            starve_d = starve_q + StvW'(1);
        end

        // Clear before set so a same-cycle issue to the popped register stays busy.
        busy_d = busy_q;
        if (pop) begin
            busy_d[head_rd] = 1'b0;
        end
        if (issue_en && (issue_rd != 5'd0)) begin
            busy_d[issue_rd] = 1'b1;
        end
        busy_d[0] = 1'b0;

        rf_we_d    = pop || alu_req;
        rf_rd_d    = '0;
        rf_wdata_d = '0;
        if (pop) begin
            rf_rd_d    = head_rd;
            rf_wdata_d = head_data;
        end else if (alu_req) begin
            rf_rd_d    = alu_wb_rd;
            rf_wdata_d = alu_wb_data;
        end

        waw_d = alu_req && busy_q[alu_wb_rd];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            starve_q   <= '0;
            busy_q     <= '0;
            rf_we_q    <= 1'b0;
            rf_rd_q    <= '0;
            rf_wdata_q <= '0;
            waw_q      <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PtrW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PtrW'(1);
            end
            count_q    <= count_d;
            starve_q   <= starve_d;
            busy_q     <= busy_d;
            rf_we_q    <= rf_we_d;
            rf_rd_q    <= rf_rd_d;
            rf_wdata_q <= rf_wdata_d;
            waw_q      <= waw_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            rd_mem[wr_ptr_q]   <= lsu_wb_rd;
            data_mem[wr_ptr_q] <= lsu_wb_data;
        end
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed scenarios plus randomized traffic checked
// against a queue-based reference model.
module tb_regfile_wb_arbiter;

    localparam int DEPTH = 4;
    localparam int SMAX  = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        alu_wb_en;
    logic [4:0]  alu_wb_rd;
    logic [31:0] alu_wb_data;
    logic        lsu_wb_valid;
    logic        lsu_wb_ready;
    logic [4:0]  lsu_wb_rd;
    logic [31:0] lsu_wb_data;
    logic        issue_en;
    logic [4:0]  issue_rd;
    logic [31:0] busy_mask;
    logic        alu_stall;
    logic        waw_err;
    logic        rf_we;
    logic [4:0]  rf_rd;
    logic [31:0] rf_wdata;
    logic [2:0]  fifo_count;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    int          q_rd[$];
    logic [31:0] q_data[$];
    logic [31:0] m_busy;
    int          m_starve;
    logic        m_we;
    logic [4:0]  m_rd;
    logic [31:0] m_data;
    logic        m_waw;

    regfile_wb_arbiter #(
        .XLEN      (32),
        .FIFO_DEPTH(DEPTH),
        .STARVE_MAX(SMAX)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .alu_wb_en   (alu_wb_en),
        .alu_wb_rd   (alu_wb_rd),
        .alu_wb_data (alu_wb_data),
        .lsu_wb_valid(lsu_wb_valid),
        .lsu_wb_ready(lsu_wb_ready),
        .lsu_wb_rd   (lsu_wb_rd),
        .lsu_wb_data (lsu_wb_data),
        .issue_en    (issue_en),
        .issue_rd    (issue_rd),
        .busy_mask   (busy_mask),
        .alu_stall   (alu_stall),
        .waw_err     (waw_err),
        .rf_we       (rf_we),
        .rf_rd       (rf_rd),
        .rf_wdata    (rf_wdata),
        .fifo_count  (fifo_count)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        q_rd.delete();
        q_data.delete();
        m_busy   = '0;
        m_starve = 0;
        m_we     = 1'b0;
        m_rd     = '0;
        m_data   = '0;
        m_waw    = 1'b0;
    endtask

    // One clock of the write-port rules, evaluated on the pre-edge state.
    task automatic model_step();
        int sz;
        bit stalled;
        bit ready;
        bit do_pop;
        bit do_alu;
        sz      = q_rd.size();
        stalled = (m_starve >= SMAX);
        ready   = (sz < DEPTH);
        do_pop  = 0;
        do_alu  = 0;
        if (stalled && sz > 0) do_pop = 1;
        else if (!stalled && alu_wb_en && alu_wb_rd != 0) do_alu = 1;
        else if (sz > 0) do_pop = 1;
        m_waw = do_alu && m_busy[alu_wb_rd];
        if (do_pop) begin
            m_we   = 1'b1;
            m_rd   = 5'(q_rd[0]);
            m_data = q_data[0];
            m_busy[q_rd[0]] = 1'b0;
            void'(q_rd.pop_front());
            void'(q_data.pop_front());
        end else if (do_alu) begin
            m_we   = 1'b1;
            m_rd   = alu_wb_rd;
            m_data = alu_wb_data;
        end else begin
            m_we = 1'b0;
        end
        if (issue_en && issue_rd != 0) m_busy[issue_rd] = 1'b1;
        m_starve = (do_pop || sz == 0) ? 0 : m_starve + 1;
        if (lsu_wb_valid && ready && lsu_wb_rd != 0) begin
            q_rd.push_back(int'(lsu_wb_rd));
            q_data.push_back(lsu_wb_data);
        end
    endtask

    task automatic drive_idle();
        alu_wb_en    = 1'b0;
        alu_wb_rd    = '0;
        alu_wb_data  = '0;
        lsu_wb_valid = 1'b0;
        lsu_wb_rd    = '0;
        lsu_wb_data  = '0;
        issue_en     = 1'b0;
        issue_rd     = '0;
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic apply_reset();
        drive_idle();
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        apply_reset();
        checks++;
        if ({rf_we, rf_rd, rf_wdata, fifo_count, busy_mask, alu_stall, waw_err} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: got we=%0b rd=%0d data=%h cnt=%0d busy=%h stall=%0b waw=%0b required all 0",
                     rf_we, rf_rd, rf_wdata, fifo_count, busy_mask, alu_stall, waw_err);
        end
        checks++;
        if (lsu_wb_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_ready: got %0b required 1", lsu_wb_ready);
        end
    endtask

    task automatic test_alu_basic();
        apply_reset();
        alu_wb_en = 1'b1; alu_wb_rd = 5'd5; alu_wb_data = 32'hDEADBEEF;
        cycle();
        drive_idle();
        checks++;
        if (rf_we !== 1'b1 || rf_rd !== 5'd5 || rf_wdata !== 32'hDEADBEEF || waw_err !== 1'b0) begin
            failures++;
            $display("FAIL alu_write: got we=%0b rd=%0d data=%h waw=%0b required we=1 rd=5 data=deadbeef waw=0",
                     rf_we, rf_rd, rf_wdata, waw_err);
        end
        cycle();
        checks++;
        if (rf_we !== 1'b0) begin
            failures++;
            $display("FAIL alu_one_shot: got rf_we=%0b required 0", rf_we);
        end
    endtask

    task automatic test_lsu_basic();
        apply_reset();
        issue_en = 1'b1; issue_rd = 5'd7;
        cycle();
        drive_idle();
        checks++;
        if (busy_mask !== 32'h80) begin
            failures++;
            $display("FAIL lsu_issue_busy: got %h required 00000080", busy_mask);
        end
        lsu_wb_valid = 1'b1; lsu_wb_rd = 5'd7; lsu_wb_data = 32'h12;
        cycle();
        drive_idle();
        checks++;
        if (fifo_count !== 3'd1 || rf_we !== 1'b0 || busy_mask[7] !== 1'b1) begin
            failures++;
            $display("FAIL lsu_buffered: got cnt=%0d we=%0b busy7=%0b required cnt=1 we=0 busy7=1",
                     fifo_count, rf_we, busy_mask[7]);
        end
        cycle();
        checks++;
        if (rf_we !== 1'b1 || rf_rd !== 5'd7 || rf_wdata !== 32'h12 || busy_mask[7] !== 1'b0
            || fifo_count !== 3'd0) begin
            failures++;
            $display("FAIL lsu_pop: got we=%0b rd=%0d data=%h busy7=%0b cnt=%0d required 1 7 12 0 0",
                     rf_we, rf_rd, rf_wdata, busy_mask[7], fifo_count);
        end
    endtask

    task automatic test_starvation();
        int got[$];
        bit stall_seen;
        apply_reset();
        stall_seen = 0;
        for (int i = 0; i < 4; i++) begin
            alu_wb_en = 1'b1; alu_wb_rd = 5'd10; alu_wb_data = 32'hA0A00000 + i;
            lsu_wb_valid = 1'b1; lsu_wb_rd = 5'(i + 1); lsu_wb_data = 32'h100 + i + 1;
            cycle();
            if (rf_we && rf_wdata[31:8] == 24'h1) got.push_back(int'(rf_rd));
        end
        checks++;
        if (fifo_count !== 3'd4 || lsu_wb_ready !== 1'b0) begin
            failures++;
            $display("FAIL starve_full: got cnt=%0d ready=%0b required cnt=4 ready=0",
                     fifo_count, lsu_wb_ready);
        end
        lsu_wb_rd = 5'd5; lsu_wb_data = 32'h105;
        cycle();
        lsu_wb_valid = 1'b0;
        checks++;
        if (fifo_count !== 3'd4) begin
            failures++;
            $display("FAIL starve_full_reject: got cnt=%0d required 4", fifo_count);
        end
        for (int i = 0; i < 40; i++) begin
            alu_wb_en = !alu_stall; alu_wb_rd = 5'd10; alu_wb_data = 32'hB0B00000 + i;
            cycle();
            if (rf_we && rf_wdata[31:8] == 24'h1) got.push_back(int'(rf_rd));
            if (alu_stall) stall_seen = 1;
            checks++;
            if (alu_stall !== (m_starve >= SMAX)) begin
                failures++;
                $display("FAIL starve_stall cyc=%0d: got %0b required %0b",
                         i, alu_stall, m_starve >= SMAX);
            end
        end
        drive_idle();
        repeat (4) begin
            cycle();
            if (rf_we && rf_wdata[31:8] == 24'h1) got.push_back(int'(rf_rd));
        end
        checks++;
        if (!stall_seen) begin
            failures++;
            $display("FAIL starve_stall_seen: got 0 required 1");
        end
        checks++;
        if (got.size() != 4) begin
            failures++;
            $display("FAIL starve_drain_count: got %0d required 4", got.size());
        end else begin
            for (int k = 0; k < 4; k++) begin
                checks++;
                if (got[k] != k + 1) begin
                    failures++;
                    $display("FAIL starve_order[%0d]: got rd=%0d required %0d", k, got[k], k + 1);
                end
            end
        end
    endtask

    task automatic test_rd_zero();
        apply_reset();
        alu_wb_en = 1'b1; alu_wb_rd = 5'd10; alu_wb_data = 32'hAAAA;
        lsu_wb_valid = 1'b1; lsu_wb_rd = 5'd8; lsu_wb_data = 32'h808;
        cycle();
        checks++;
        if (rf_we !== 1'b1 || rf_rd !== 5'd10 || fifo_count !== 3'd1) begin
            failures++;
            $display("FAIL rd0_setup: got we=%0b rd=%0d cnt=%0d required 1 10 1", rf_we, rf_rd, fifo_count);
        end
        alu_wb_rd = 5'd0; alu_wb_data = 32'hBAD;
        lsu_wb_rd = 5'd9; lsu_wb_data = 32'h909;
        cycle();
        drive_idle();
        checks++;
        if (rf_we !== 1'b1 || rf_rd !== 5'd8 || rf_wdata !== 32'h808 || fifo_count !== 3'd1) begin
            failures++;
            $display("FAIL rd0_first: got we=%0b rd=%0d data=%h cnt=%0d required 1 8 808 1",
                     rf_we, rf_rd, rf_wdata, fifo_count);
        end
        cycle();
        checks++;
        if (rf_we !== 1'b1 || rf_rd !== 5'd9 || rf_wdata !== 32'h909 || fifo_count !== 3'd0) begin
            failures++;
            $display("FAIL rd0_second: got we=%0b rd=%0d data=%h cnt=%0d required 1 9 909 0",
                     rf_we, rf_rd, rf_wdata, fifo_count);
        end
        cycle();
        checks++;
        if (rf_we !== 1'b0) begin
            failures++;
            $display("FAIL rd0_idle: got rf_we=%0b required 0", rf_we);
        end
    endtask

    task automatic test_waw();
        apply_reset();
        issue_en = 1'b1; issue_rd = 5'd3;
        cycle();
        drive_idle();
        alu_wb_en = 1'b1; alu_wb_rd = 5'd3; alu_wb_data = 32'h33;
        cycle();
        drive_idle();
        checks++;
        if (waw_err !== 1'b1 || rf_we !== 1'b1 || rf_rd !== 5'd3 || rf_wdata !== 32'h33
            || busy_mask[3] !== 1'b1) begin
            failures++;
            $display("FAIL waw_pulse: got waw=%0b we=%0b rd=%0d data=%h busy3=%0b required 1 1 3 33 1",
                     waw_err, rf_we, rf_rd, rf_wdata, busy_mask[3]);
        end
        cycle();
        checks++;
        if (waw_err !== 1'b0 || busy_mask[3] !== 1'b1) begin
            failures++;
            $display("FAIL waw_one_cycle: got waw=%0b busy3=%0b required waw=0 busy3=1",
                     waw_err, busy_mask[3]);
        end
    endtask

    task automatic test_async_reset();
        apply_reset();
        for (int i = 0; i < 3; i++) begin
            alu_wb_en = 1'b1; alu_wb_rd = 5'd10; alu_wb_data = 32'hC0 + i;
            lsu_wb_valid = 1'b1; lsu_wb_rd = 5'(i + 1); lsu_wb_data = 32'h200 + i;
            issue_en = 1'b1; issue_rd = 5'(i + 1);
            cycle();
        end
        drive_idle();
        checks++;
        if (fifo_count !== 3'd3 || rf_we !== 1'b1 || busy_mask !== 32'h0E) begin
            failures++;
            $display("FAIL arst_setup: got cnt=%0d we=%0b busy=%h required 3 1 0000000e",
                     fifo_count, rf_we, busy_mask);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({rf_we, rf_rd, rf_wdata, fifo_count, busy_mask, alu_stall, waw_err} !== '0
            || lsu_wb_ready !== 1'b1) begin
            failures++;
            $display("FAIL arst_immediate: got we=%0b rd=%0d data=%h cnt=%0d busy=%h stall=%0b waw=%0b ready=%0b required zeros, ready=1",
                     rf_we, rf_rd, rf_wdata, fifo_count, busy_mask, alu_stall, waw_err, lsu_wb_ready);
        end
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        cycle();
        checks++;
        if (fifo_count !== 3'd0 || busy_mask !== 32'h0 || rf_we !== 1'b0) begin
            failures++;
            $display("FAIL arst_release: got cnt=%0d busy=%h we=%0b required 0 0 0",
                     fifo_count, busy_mask, rf_we);
        end
    endtask

    task automatic test_random();
        logic [2:0] exp_cnt;
        apply_reset();
        for (int i = 0; i < 400; i++) begin
            alu_wb_en    = ($urandom_range(0, 99) < 60);
            alu_wb_rd    = 5'($urandom_range(0, 7));
            alu_wb_data  = $urandom;
            lsu_wb_valid = ($urandom_range(0, 99) < 50);
            lsu_wb_rd    = 5'($urandom_range(0, 7));
            lsu_wb_data  = $urandom;
            issue_en     = ($urandom_range(0, 99) < 30);
            issue_rd     = 5'($urandom_range(0, 7));
            cycle();
            exp_cnt = 3'(q_rd.size());
            checks++;
            if (rf_we !== m_we) begin
                failures++;
                $display("FAIL rand_rf_we cyc=%0d: got %0b required %0b", i, rf_we, m_we);
            end
            if (m_we) begin
                checks++;
                if (rf_rd !== m_rd || rf_wdata !== m_data) begin
                    failures++;
                    $display("FAIL rand_rf_write cyc=%0d: got rd=%0d data=%h required rd=%0d data=%h",
                             i, rf_rd, rf_wdata, m_rd, m_data);
                end
            end
            checks++;
            if (fifo_count !== exp_cnt || lsu_wb_ready !== (q_rd.size() < DEPTH)) begin
                failures++;
                $display("FAIL rand_fifo cyc=%0d: got cnt=%0d ready=%0b required cnt=%0d ready=%0b",
                         i, fifo_count, lsu_wb_ready, exp_cnt, q_rd.size() < DEPTH);
            end
            checks++;
            if (busy_mask !== m_busy) begin
                failures++;
                $display("FAIL rand_busy cyc=%0d: got %h required %h", i, busy_mask, m_busy);
            end
            checks++;
            if (alu_stall !== (m_starve >= SMAX) || waw_err !== m_waw) begin
                failures++;
                $display("FAIL rand_stall_waw cyc=%0d: got stall=%0b waw=%0b required stall=%0b waw=%0b",
                         i, alu_stall, waw_err, m_starve >= SMAX, m_waw);
            end
        end
        drive_idle();
    endtask

    initial begin
        rst_n = 1'b0;
        drive_idle();
        model_reset();
        test_reset();
        test_alu_basic();
        test_lsu_basic();
        test_starvation();
        test_rd_zero();
        test_waw();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
